// File: rtl/search_pkg.sv
// Shared sizing constants and FSM state encoding for the search host and its
// element loader.
package search_pkg;
    localparam int N = 10;
    localparam int W = 7;
    localparam int LOC_W = 4;
    localparam int CNT_W = 7;
    localparam int CYC_W = 8;
    localparam int IDX_W = $clog2(N);
    localparam logic [LOC_W-1:0] TIMEOUT_LOC = 4'hF;

    typedef enum logic [2:0] {
        LOAD,
        ARM,
        WAIT,
        ACK,
        RESULT
    } state_t;
endpackage

// File: rtl/element_loader.sv
// Serial-to-parallel dataset register: one element per accepted beat, element 0
// first, flagging the beat that completes the dataset.
module element_loader
    import search_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load_en,
    input  logic           beat_valid,
    input  logic [W-1:0]   beat_data,
    output logic           last_beat,
    output logic [N*W-1:0] elem_bus
);

    logic [IDX_W-1:0] idx;
    logic             accept;

    assign accept    = load_en && beat_valid;
    assign last_beat = accept && (idx == IDX_W'(N - 1));

    // The bus only changes on an accepted beat, so the engine sees a frozen
    // dataset for the whole search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            elem_bus <= '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (idx == IDX_W'(k)) begin
                    elem_bus[k*W +: W] <= beat_data;
                end
            end
            idx <= last_beat ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/search_host.sv
// Initiator for the element-search engine: loads a dataset, runs one
// START/Done/ACK search under a timeout guard and returns the result.
module search_host
    import search_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [N*W-1:0]   elem_bus,
    output logic             search_start,
    input  logic             search_done,
    input  logic [LOC_W-1:0] search_location,
    input  logic [CNT_W-1:0] search_count,
    output logic             search_ack,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [LOC_W-1:0] res_location,
    output logic [CNT_W-1:0] res_count,
    output logic [CYC_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic             busy
);

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t           state;
    logic [CYC_W-1:0] wait_cnt;
    logic [CYC_W-1:0] wait_next;
    logic             last_beat;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign wait_next = sat_inc(wait_cnt);

    element_loader u_loader (
        .clk        (clk),
        .reset      (reset),
        .load_en    (in_ready),
        .beat_valid (in_valid),
        .beat_data  (in_data),
        .last_beat  (last_beat),
        .elem_bus   (elem_bus)
    );

    // wait_next counts the current WAIT cycle, so a Done in the first WAIT
    // cycle reports 1 and the timeout fires on the TIMEOUT-th cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD;
            wait_cnt     <= '0;
            search_start <= 1'b0;
            search_ack   <= 1'b0;
            res_valid    <= 1'b0;
            res_location <= '0;
            res_count    <= '0;
            res_cycles   <= '0;
            res_timeout  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (last_beat) begin
                        search_start <= 1'b1;
                        state        <= ARM;
                    end
                end
                ARM: begin
                    search_start <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_next;
                    if (search_done) begin
                        res_location <= search_location;
                        res_count    <= search_count;
                        res_cycles   <= wait_next;
                        res_timeout  <= 1'b0;
                        search_ack   <= 1'b1;
                        state        <= ACK;
                    end else if (wait_next >= CYC_W'(TIMEOUT)) begin
                        res_location <= TIMEOUT_LOC;
                        res_count    <= '0;
                        res_cycles   <= wait_next;
                        res_timeout  <= 1'b1;
                        search_ack   <= 1'b1;
                        state        <= ACK;
                    end
                end
                ACK: begin
                    if (!search_done) begin
                        search_ack <= 1'b0;
                        res_valid  <= 1'b1;
                        state      <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_search_host.sv
// Bench for search_host: randomized loads and engine behaviour checked every
// cycle against a spec-level model, plus a short-timeout instance.
module tb_search_host;
    import search_pkg::*;

    localparam int TO_MAIN  = 255;
    localparam int TO_SHORT = 20;
    localparam int M_LOAD = 0, M_ARM = 1, M_WAIT = 2, M_ACK = 3, M_RES = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic [N*W-1:0] elem_bus;
    logic           search_start;
    logic           search_done = 1'b0;
    logic [3:0]     search_location = '0;
    logic [6:0]     search_count = '0;
    logic           search_ack;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [3:0]     res_location;
    logic [6:0]     res_count;
    logic [7:0]     res_cycles;
    logic           res_timeout;
    logic           busy;

    logic           t_in_valid = 1'b0;
    logic [W-1:0]   t_in_data = '0;
    logic           t_in_ready;
    logic [N*W-1:0] t_elem_bus;
    logic           t_search_start;
    logic           t_done = 1'b0;
    logic [3:0]     t_loc = '0;
    logic [6:0]     t_cnt = '0;
    logic           t_search_ack;
    logic           t_res_valid;
    logic           t_res_ready = 1'b0;
    logic [3:0]     t_res_location;
    logic [6:0]     t_res_count;
    logic [7:0]     t_res_cycles;
    logic           t_res_timeout;
    logic           t_busy;

    search_host #(.TIMEOUT(TO_MAIN)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .elem_bus(elem_bus), .search_start(search_start), .search_done(search_done),
        .search_location(search_location), .search_count(search_count), .search_ack(search_ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_location(res_location),
        .res_count(res_count), .res_cycles(res_cycles), .res_timeout(res_timeout), .busy(busy)
    );

    search_host #(.TIMEOUT(TO_SHORT)) u_short (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
        .elem_bus(t_elem_bus), .search_start(t_search_start), .search_done(t_done),
        .search_location(t_loc), .search_count(t_cnt), .search_ack(t_search_ack),
        .res_valid(t_res_valid), .res_ready(t_res_ready), .res_location(t_res_location),
        .res_count(t_res_count), .res_cycles(t_res_cycles), .res_timeout(t_res_timeout), .busy(t_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_bus(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] v [N]);
        logic [N*W-1:0] b;
        b = '0;
        for (int k = 0; k < N; k++) b[k*W +: W] = v[k];
        return b;
    endfunction

    // Spec-level reference: phase of the search, slots written so far and the
    // last reported result.
    int         m_phase, m_beats, m_waited, m_cyc;
    logic [W-1:0] m_slot [N];
    logic [3:0] m_loc;
    logic [6:0] m_cnt;
    logic       m_to;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = M_LOAD; m_beats = 0; m_waited = 0;
            for (int k = 0; k < N; k++) m_slot[k] = '0;
            m_loc = '0; m_cnt = '0; m_cyc = 0; m_to = 1'b0;
        end else begin
            case (m_phase)
                M_LOAD: if (in_valid) begin
                    m_slot[m_beats] = in_data;
                    if (m_beats == N - 1) begin m_beats = 0; m_phase = M_ARM; end
                    else m_beats = m_beats + 1;
                end
                M_ARM: begin m_waited = 0; m_phase = M_WAIT; end
                M_WAIT: begin
                    m_waited = (m_waited < 255) ? m_waited + 1 : 255;
                    if (search_done) begin
                        m_loc = search_location; m_cnt = search_count; m_cyc = m_waited; m_to = 1'b0;
                        m_phase = M_ACK;
                    end else if (m_waited == TO_MAIN) begin
                        m_loc = 4'hF; m_cnt = '0; m_cyc = m_waited; m_to = 1'b1;
                        m_phase = M_ACK;
                    end
                end
                M_ACK: if (!search_done) m_phase = M_RES;
                default: if (res_ready) m_phase = M_LOAD;
            endcase
        end
    end

    always @(negedge clk) begin
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_phase == M_LOAD));
        chk("busy", 32'(busy), 32'(m_phase != M_LOAD));
        chk("search_start", 32'(search_start), 32'(m_phase == M_ARM));
        chk("search_ack", 32'(search_ack), 32'(m_phase == M_ACK));
        chk("res_valid", 32'(res_valid), 32'(m_phase == M_RES));
        chk_bus("elem_bus", elem_bus, pack(m_slot));
        chk("res_location", 32'(res_location), 32'(m_loc));
        chk("res_count", 32'(res_count), 32'(m_cnt));
        chk("res_cycles", 32'(res_cycles), 32'(m_cyc));
        chk("res_timeout", 32'(res_timeout), 32'(m_to));
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (search_start) start_pulses++;
    end

    // Engine model: Done after eng_lat WAIT cycles (0 = never), held eng_hold
    // cycles past ACK; random Done noise while the host should ignore it.
    int         eng_lat = 1, eng_hold = 0, done_cyc = 0;
    logic [3:0] eng_loc = '0;
    logic [6:0] eng_cnt = '0;
    bit         noise_en = 1'b0;

    initial begin
        int e_state, e_cd, e_hold;
        e_state = 0; e_cd = 0; e_hold = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                e_state = 0;
                search_done = 1'b0;
            end else begin
                case (e_state)
                    0: if (search_start) begin
                        search_done = 1'b0;
                        e_cd = eng_lat;
                        e_state = (eng_lat == 0) ? 3 : 1;
                    end else begin
                        search_done = noise_en && (in_ready || res_valid) && ($urandom_range(0, 3) == 0);
                        search_location = 4'($urandom);
                        search_count = 7'($urandom);
                    end
                    1: begin
                        e_cd--;
                        if (e_cd == 0) begin
                            search_done = 1'b1;
                            search_location = eng_loc;
                            search_count = eng_cnt;
                            done_cyc = cyc;
                            e_state = 2;
                        end
                    end
                    2: if (search_ack) begin e_hold = eng_hold; e_state = 4; end
                    3: if (search_ack) e_state = 0;
                    default: if (e_hold == 0) begin search_done = 1'b0; e_state = 0; end
                             else e_hold--;
                endcase
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(search_start), 32'd0);
        chk({tag, "_ack"}, 32'(search_ack), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk_bus({tag, "_elem_bus"}, elem_bus, '0);
        chk({tag, "_res_fields"}, 32'({res_location, res_count, res_cycles, res_timeout}), 32'd0);
    endtask

    task automatic load_set(input logic [W-1:0] v [N], input bit gappy);
        int i, budget;
        i = 0; budget = 0;
        while (i < N && budget < 500) begin
            @(negedge clk);
            budget++;
            chk("no_early_start", 32'(search_start), 32'd0);
            if (gappy && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data = W'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data = v[i];
                if (in_ready) i++;
            end
        end
        chk("load_bound", 32'(i), 32'(N));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_search(input logic [W-1:0] v [N], input bit gappy, input int lat, input int hold,
                              input logic [3:0] loc, input logic [6:0] cnt, input int rdy);
        int n, p0, r;
        eng_lat = lat; eng_hold = hold; eng_loc = loc; eng_cnt = cnt;
        p0 = start_pulses;
        load_set(v, gappy);
        chk("start_at_arm", 32'(search_start), 32'd1);
        if (rdy == 0) res_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 600) begin @(negedge clk); n++; end
        chk("res_valid_seen", 32'(res_valid), 32'd1);
        r = cyc;
        chk_bus("dataset", elem_bus, pack(v));
        chk("start_pulses", 32'(start_pulses - p0), 32'd1);
        if (lat != 0 && lat <= TO_MAIN) begin
            chk("exp_location", 32'(res_location), 32'(loc));
            chk("exp_count", 32'(res_count), 32'(cnt));
            chk("exp_cycles", 32'(res_cycles), 32'(lat));
            chk("exp_timeout", 32'(res_timeout), 32'd0);
            chk("done_to_valid", 32'(r - done_cyc), 32'(3 + hold));
        end else begin
            chk("exp_location", 32'(res_location), 32'hF);
            chk("exp_count", 32'(res_count), 32'd0);
            chk("exp_cycles", 32'(res_cycles), 32'(TO_MAIN));
            chk("exp_timeout", 32'(res_timeout), 32'd1);
        end
        if (rdy > 0) begin
            repeat (rdy) begin
                @(negedge clk);
                chk("held_in_ready", 32'(in_ready), 32'd0);
            end
            res_ready = 1'b1;
        end
        @(negedge clk);
        res_ready = 1'b0;
        chk("load_resume", 32'(in_ready), 32'd1);
    endtask

    task automatic short_timeout();
        logic [W-1:0] v [N];
        int w;
        for (int k = 0; k < N; k++) begin
            v[k] = W'(k + 11);
            @(negedge clk);
            t_in_valid = 1'b1;
            t_in_data = v[k];
        end
        @(negedge clk);
        t_in_valid = 1'b0;
        chk("t_start", 32'(t_search_start), 32'd1);
        chk_bus("t_dataset", t_elem_bus, pack(v));
        w = 0;
        @(negedge clk);
        while (!t_search_ack && w < 100) begin
            chk("t_busy", 32'(t_busy), 32'd1);
            w++;
            @(negedge clk);
        end
        chk("t_wait_cycles", 32'(w), 32'(TO_SHORT));
        @(negedge clk);
        chk("t_ack_one_cycle", 32'(t_search_ack), 32'd0);
        chk("t_res_valid", 32'(t_res_valid), 32'd1);
        chk("t_location", 32'(t_res_location), 32'hF);
        chk("t_count", 32'(t_res_count), 32'd0);
        chk("t_cycles", 32'(t_res_cycles), 32'(TO_SHORT));
        chk("t_timeout", 32'(t_res_timeout), 32'd1);
        t_res_ready = 1'b1;
        @(negedge clk);
        t_res_ready = 1'b0;
        chk("t_load_resume", 32'(t_in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v [N];
        repeat (3) @(negedge clk);
        reset_checks("por");
        reset = 1'b0;

        short_timeout();
        noise_en = 1'b1;

        v = '{7'd5, 7'd3, 7'd9, 7'd1, 7'd7, 7'd2, 7'd8, 7'd4, 7'd6, 7'd0};
        run_search(v, 1'b0, 30, 0, 4'd4, 7'd23, 0);
        chk("pin_loc", 32'(m_loc), 32'd4);
        chk("pin_cnt", 32'(m_cnt), 32'd23);
        chk("pin_cyc", 32'(m_cyc), 32'd30);
        chk("pin_to", 32'(m_to), 32'd0);
        chk("pin_slot9", 32'(elem_bus[9*W +: W]), 32'd0);
        chk("pin_slot2", 32'(elem_bus[2*W +: W]), 32'd9);

        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < N; k++) v[k] = W'($urandom);
            run_search(v, 1'b1, int'($urandom_range(1, 60)), int'($urandom_range(0, 3)),
                       4'($urandom), 7'($urandom), int'($urandom_range(0, 6)));
        end

        run_search(v, 1'b1, 12, 3, 4'd7, 7'd40, 2);
        for (int k = 0; k < N; k++) v[k] = W'($urandom);
        run_search(v, 1'b0, 8, 0, 4'd2, 7'd5, 50);

        run_search(v, 1'b0, 0, 0, 4'd1, 7'd1, 1);
        chk("pin_to_flag", 32'(m_to), 32'd1);
        chk("pin_to_cyc", 32'(m_cyc), 32'd255);
        chk("pin_to_loc", 32'(m_loc), 32'hF);

        run_search(v, 1'b0, 255, 0, 4'd9, 7'd99, 0);
        chk("pin_edge_cyc", 32'(m_cyc), 32'd255);
        chk("pin_edge_to", 32'(m_to), 32'd0);

        eng_lat = 100;
        eng_hold = 0;
        load_set(v, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        reset_checks("rst_wait");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = W'($urandom_range(1, 127));
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        reset_checks("rst_load");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < N; k++) v[k] = W'($urandom);
        run_search(v, 1'b1, 17, 1, 4'd6, 7'd77, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
